alu_mem_sequencer: RTL and testbench

Parametrised multi-cycle datapath: register file, ALU and single-port synchronous data memory under one command-driven controller FSM. Each accepted command (ALU op, load, store, load-immediate) runs to completion, writes back, reports result and flags with a one-cycle `done` pulse. Next generation of the lab datapath. Widths and depths are generic, memory is properly sequenced, and `slt`/`sll` semantics are fixed.

---
 rtl/seq_pkg.sv | 33 +++
 rtl/alu_core.sv | 56 +++++
 rtl/alu_mem_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_mem_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// Module  : seq_pkg
// Brief   : Command/ALU encodings and controller state type for alu_mem_sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam logic [1:0] CMD_ALU   = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;
    localparam logic [1:0] CMD_LOADI = 2'b11;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module  : alu_core
// Brief   : Combinational ALU: logic ops, add/sub with signed overflow, slt, sll.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu_core #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_f,
    output logic              o_zf,
    output logic              o_of
);
    import seq_pkg::*;

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_f  = '0;
        o_of = 1'b0;
        case (i_op)
            OP_AND: o_f = i_a & i_b;
            OP_OR:  o_f = i_a | i_b;
            OP_XOR: o_f = i_a ^ i_b;
            OP_NOR: o_f = ~(i_a | i_b);
            OP_ADD: begin
                o_f  = w_sum;
                o_of = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                o_f  = w_diff;
                o_of = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_SLT: o_f = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            // Only the low log2(DATA_W) bits of A count, so oversized amounts wrap.
            OP_SLL: o_f = i_b << i_a[SH_W-1:0];
            default: o_f = '0;
        endcase
    end

    assign o_zf = (o_f == '0);

endmodule

`default_nettype wire

// File: rtl/alu_mem_sequencer.sv
// ============================================================================
// Module  : alu_mem_sequencer
// Brief   : Register file + ALU + sync data memory driven by a serial command FSM.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu_mem_sequencer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 6
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic [2:0]        alu_op,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] imm,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ZF,
    output logic              OF,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import seq_pkg::*;

    localparam int NREG = 1 << REG_AW;
    localparam int NMEM = 1 << MEM_AW;

    state_t            r_state, w_next;
    logic [1:0]        r_cmd;
    logic [2:0]        r_op;
    logic [REG_AW-1:0] r_rd, r_rs, r_rt;
    logic [MEM_AW-1:0] r_maddr;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_mem  [NMEM];
    logic [DATA_W-1:0] r_mem_rdata;
    logic [DATA_W-1:0] r_result;
    logic              r_zf, r_of;

    logic [DATA_W-1:0] w_rs_val, w_rt_val, w_alu_f, w_res;
    logic              w_alu_zf, w_alu_of, w_zf, w_of;
    logic              w_wb, w_mem_we, w_reg_we;

    always_ff @(posedge clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_next = ST_EXEC;
            ST_EXEC:     w_next = (r_cmd == CMD_LOAD) ? ST_MEM_WAIT : ST_DONE;
            ST_MEM_WAIT: w_next = ST_DONE;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Write-back happens in EXEC, except LOAD which waits one cycle for read data.
    always_comb begin
        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_DONE);
        w_wb     = 1'b0;
        w_mem_we = 1'b0;
        case (r_state)
            ST_EXEC: begin
                w_wb     = (r_cmd != CMD_LOAD);
                w_mem_we = (r_cmd == CMD_STORE);
            end
            ST_MEM_WAIT: w_wb = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && start) begin
            r_cmd   <= cmd;
            r_op    <= alu_op;
            r_rd    <= rd;
            r_rs    <= rs;
            r_rt    <= rt;
            r_maddr <= mem_addr;
            r_imm   <= imm;
        end
    end

    assign w_rs_val = (r_rs == '0) ? '0 : r_regs[r_rs];
    assign w_rt_val = (r_rt == '0) ? '0 : r_regs[r_rt];

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .i_a  (w_rs_val),
        .i_b  (w_rt_val),
        .i_op (r_op),
        .o_f  (w_alu_f),
        .o_zf (w_alu_zf),
        .o_of (w_alu_of)
    );

    always_comb begin
        w_res = '0;
        w_of  = 1'b0;
        case (r_cmd)
            CMD_ALU: begin
                w_res = w_alu_f;
                w_of  = w_alu_of;
            end
            CMD_LOAD:  w_res = r_mem_rdata;
            CMD_STORE: w_res = w_rt_val;
            CMD_LOADI: w_res = r_imm;
            default:   w_res = '0;
        endcase
        w_zf = (r_cmd == CMD_ALU) ? w_alu_zf : (w_res == '0);
    end

    assign w_reg_we = w_wb && (r_cmd != CMD_STORE) && (r_rd != '0);

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_reg_we) begin
            r_regs[r_rd] <= w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_result <= '0;
            r_zf     <= 1'b0;
            r_of     <= 1'b0;
        end else if (w_wb) begin
            r_result <= w_res;
            r_zf     <= w_zf;
            r_of     <= w_of;
        end
    end

    // Memory is not cleared by reset; only the in-flight store is suppressed.
    always_ff @(posedge clk) begin
        if (w_mem_we && !Reset) r_mem[r_maddr] <= w_rt_val;
        r_mem_rdata <= r_mem[r_maddr];
    end

    assign result   = r_result;
    assign ZF       = r_zf;
    assign OF       = r_of;
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu_mem_sequencer.sv
// ============================================================================
// Module  : tb_alu_mem_sequencer
// Brief   : Self-checking bench: directed plan plus randomized commands vs model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mem_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cmd = '0;
    logic [2:0]  alu_op = '0;
    logic [4:0]  rd = '0, rs = '0, rt = '0, dbg_addr = '0;
    logic [5:0]  mem_addr = '0;
    logic [31:0] imm = '0;
    logic        busy, done, ZF, OF;
    logic [31:0] result, dbg_data;

    always #5 clk = ~clk;

    alu_mem_sequencer #(.DATA_W(32), .REG_AW(5), .MEM_AW(6)) dut (
        .clk(clk), .Reset(Reset), .start(start), .cmd(cmd), .alu_op(alu_op),
        .rd(rd), .rs(rs), .rt(rt), .mem_addr(mem_addr), .imm(imm),
        .busy(busy), .done(done), .result(result), .ZF(ZF), .OF(OF),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_zf = 1'b0, exp_of = 1'b0;
    logic [31:0] exp_result = '0;
    bit          chk_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   {31'b0, busy}, {31'b0, exp_busy});
            chk("done",   {31'b0, done}, {31'b0, exp_done});
            chk("result", result, exp_result);
            chk("ZF",     {31'b0, ZF}, {31'b0, exp_zf});
            chk("OF",     {31'b0, OF}, {31'b0, exp_of});
            chk("dbg",    dbg_data, m_reg[dbg_addr]);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_result = '0; exp_zf = 1'b0; exp_of = 1'b0;
    endtask

    task automatic model_eval(input logic [1:0] c, input logic [2:0] op, input logic [4:0] s,
                              input logic [4:0] t, input logic [5:0] ma, input logic [31:0] im,
                              output logic [31:0] res, output logic of);
        logic [31:0] a, b;
        longint      wide;
        a = m_reg[s];
        b = m_reg[t];
        res = '0;
        of  = 1'b0;
        case (c)
            CMD_ALU: case (op)
                OP_AND: res = a & b;
                OP_OR:  res = a | b;
                OP_XOR: res = a ^ b;
                OP_NOR: res = ~(a | b);
                OP_ADD: begin
                    res  = a + b;
                    wide = longint'($signed(a)) + longint'($signed(b));
                    of   = (wide != longint'($signed(res)));
                end
                OP_SUB: begin
                    res  = a - b;
                    wide = longint'($signed(a)) - longint'($signed(b));
                    of   = (wide != longint'($signed(res)));
                end
                OP_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: res = b << (a % 32);
            endcase
            CMD_LOAD:  res = m_mem[ma];
            CMD_STORE: res = b;
            default:   res = im;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dbg_addr = 5'($urandom);
    endtask

    task automatic scramble();
        cmd = 2'($urandom); alu_op = 3'($urandom);
        rd = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom);
        mem_addr = 6'($urandom); imm = $urandom;
    endtask

    // Issues one command in IDLE and follows it to the next IDLE cycle.
    task automatic run_cmd(input logic [1:0] c, input logic [2:0] op, input logic [4:0] d,
                           input logic [4:0] s, input logic [4:0] t, input logic [5:0] ma,
                           input logic [31:0] im, input bit noise, input int pulse_k,
                           input int rst_k, output int done_at, output int busy_cnt,
                           output int done_cnt);
        logic [31:0] res;
        logic        of;
        int          lat;
        lat = (c == CMD_LOAD) ? 3 : 2;
        model_eval(c, op, s, t, ma, im, res, of);
        cmd = c; alu_op = op; rd = d; rs = s; rt = t; mem_addr = ma; imm = im;
        start = 1'b1;
        done_at = 0; busy_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= lat + 1; k++) begin
            tick();
            if (rst_k != 0 && k == rst_k + 1) begin
                Reset = 1'b0;
                start = 1'b0;
                model_reset();
                break;
            end
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = k; end
            if (k <= lat) begin
                exp_busy = 1'b1;
                exp_done = (k == lat);
                if (k == lat) begin
                    if (c == CMD_STORE) m_mem[ma] = m_reg[t];
                    else if (d != 5'd0) m_reg[d] = res;
                    exp_result = res; exp_zf = (res == 32'd0); exp_of = of;
                end
                start = (k == pulse_k) || (noise && $urandom_range(0, 2) == 0);
                scramble();
            end else begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end
            if (k == rst_k) Reset = 1'b1;
        end
    endtask

    initial begin
        int da, bc, dc, rk;
        logic [1:0] rc;
        model_reset();
        Reset = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        Reset = 1'b0;
        tick();

        run_cmd(CMD_LOADI, 0, 1, 0, 0, 0, 32'h7FFFFFFF, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_LOADI, 0, 2, 0, 0, 0, 32'h1, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_ALU, OP_ADD, 3, 1, 2, 0, 0, 0, 0, 0, da, bc, dc);
        chk("add_res", result, 32'h80000000);
        chk("add_of", {31'b0, OF}, 32'd1);
        chk("add_zf", {31'b0, ZF}, 32'd0);
        chk("add_done_lat", da, 2);
        run_cmd(CMD_ALU, OP_SUB, 4, 2, 2, 0, 0, 0, 0, 0, da, bc, dc);
        chk("sub_res", result, 32'd0);
        chk("sub_zf", {31'b0, ZF}, 32'd1);
        run_cmd(CMD_STORE, 0, 0, 0, 1, 63, 0, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_LOAD, 0, 5, 0, 0, 63, 0, 0, 0, 0, da, bc, dc);
        chk("load_res", result, 32'h7FFFFFFF);
        chk("load_done_lat", da, 3);
        chk("load_busy_cycles", bc, 3);
        run_cmd(CMD_LOADI, 0, 1, 0, 0, 0, 32'hFFFFFFFB, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_LOADI, 0, 2, 0, 0, 0, 32'd3, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_ALU, OP_SLT, 8, 1, 2, 0, 0, 0, 0, 0, da, bc, dc);
        chk("slt_neg_lt_pos", result, 32'd1);
        run_cmd(CMD_ALU, OP_SLT, 9, 2, 1, 0, 0, 0, 0, 0, da, bc, dc);
        chk("slt_pos_lt_neg", result, 32'd0);
        run_cmd(CMD_LOADI, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, da, bc, dc);
        dbg_addr = 5'd0; #1;
        chk("dbg_r0", dbg_data, 32'd0);
        run_cmd(CMD_LOADI, 0, 6, 0, 0, 0, 32'd4, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_LOADI, 0, 7, 0, 0, 0, 32'd1, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_ALU, OP_SLL, 10, 6, 7, 0, 0, 0, 0, 0, da, bc, dc);
        chk("sll_4", result, 32'h10);
        run_cmd(CMD_LOADI, 0, 6, 0, 0, 0, 32'd36, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_ALU, OP_SLL, 10, 6, 7, 0, 0, 0, 0, 0, da, bc, dc);
        chk("sll_36", result, 32'h10);
        run_cmd(CMD_LOAD, 0, 11, 0, 0, 63, 0, 0, 2, 0, da, bc, dc);
        tick(); tick();
        chk("load_pulse_one_done", dc, 1);
        run_cmd(CMD_LOADI, 0, 12, 0, 0, 0, 32'hAAAA5555, 0, 0, 1, da, bc, dc);
        chk("rst_exec_result", result, 32'd0);
        dbg_addr = 5'd12; #1;
        chk("rst_exec_no_write", dbg_data, 32'd0);
        run_cmd(CMD_LOADI, 0, 13, 0, 0, 0, 32'h55, 0, 0, 0, da, bc, dc);
        run_cmd(CMD_STORE, 0, 0, 0, 13, 63, 0, 0, 0, 1, da, bc, dc);
        run_cmd(CMD_LOAD, 0, 14, 0, 0, 63, 0, 0, 0, 0, da, bc, dc);
        chk("mem_retained", result, 32'h7FFFFFFF);

        for (int r = 1; r < 32; r++)
            run_cmd(CMD_LOADI, 0, 5'(r), 0, 0, 0, $urandom, 1, 0, 0, da, bc, dc);
        for (int a = 0; a < 64; a++)
            run_cmd(CMD_STORE, 0, 0, 0, 5'(a % 31 + 1), 6'(a), 0, 1, 0, 0, da, bc, dc);
        for (int n = 0; n < 300; n++) begin
            rc = 2'($urandom);
            rk = ($urandom_range(0, 39) == 0) ? $urandom_range(1, 2) : 0;
            run_cmd(rc, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    6'($urandom), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                    1, 0, rk, da, bc, dc);
        end
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
